// File: rtl/msg_match_pkg.sv
// Shared definitions for the unexpected-message matching path: CAM layout,
// lookup FSM encoding and the {rank,tag} address packing helper.
package msg_match_pkg;

   localparam int DEF_RANK_BIT   = 8;
   localparam int DEF_TAG_BIT    = 8;
   localparam int CAM_VALID_BIT  = 35;
   localparam int CAM_DATA_WIDTH = 32;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_ISSUE    = 3'd1,
      ST_WAIT_RES = 3'd2,
      ST_RESP     = 3'd3,
      ST_GAP      = 3'd4
   } find_state_t;

   // Rank occupies the bits above the tag field.
   function automatic logic [31:0] pack_addr(input logic [31:0] rank,
                                             input logic [31:0] tag,
                                             input int unsigned tag_bits);
      return (rank << tag_bits) | tag;
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with increment strobe and synchronous clear.
module sat_counter #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             inc,
   output logic [WIDTH-1:0] count
);

   logic [WIDTH-1:0] count_reg;

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         count_reg <= '0;
      end else if (inc && (count_reg != {WIDTH{1'b1}})) begin
         count_reg <= count_reg + WIDTH'(1);
      end
   end

   assign count = count_reg;

endmodule

// File: rtl/umq_find_ctrl.sv
// Request-side sequencer for the unexpected-message CAM: one lookup in flight,
// find strobe, bounded wait for found/not_found, response handshake, statistics.
module umq_find_ctrl
   import msg_match_pkg::*;
#(
   parameter int ADDR_WIDTH     = 16,
   parameter int RANK_BIT       = DEF_RANK_BIT,
   parameter int TAG_BIT        = DEF_TAG_BIT,
   parameter int ID_WIDTH       = 8,
   parameter int TIMEOUT_CYCLES = 15,
   parameter int STAT_WIDTH     = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [RANK_BIT-1:0]   req_rank,
   input  logic [TAG_BIT-1:0]    req_tag,
   input  logic [ID_WIDTH-1:0]   req_id,
   output logic [31:0]           request,
   output logic                  find,
   input  logic                  found,
   input  logic                  not_found,
   input  logic [31:0]           unexpected_message,
   output logic                  resp_valid,
   input  logic                  resp_ready,
   output logic                  resp_hit,
   output logic                  resp_timeout,
   output logic [31:0]           resp_data,
   output logic [ID_WIDTH-1:0]   resp_id,
   output logic [STAT_WIDTH-1:0] hit_count,
   output logic [STAT_WIDTH-1:0] miss_count,
   output logic                  proto_err
);

   localparam int          TW        = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [31:0] ADDR_MASK = (ADDR_WIDTH >= 32) ? 32'hFFFF_FFFF
                                       : ((32'd1 << ADDR_WIDTH) - 32'd1);

   find_state_t       state_reg;
   logic [TW-1:0]     tcnt_reg;
   logic              hit_inc;
   logic              miss_inc;
   logic              in_wait;
   logic [1:0]        stat_inc;
   logic [STAT_WIDTH-1:0] stat_count [2];

   assign in_wait   = (state_reg == ST_WAIT_RES);
   assign req_ready = (state_reg == ST_IDLE);
   assign hit_inc   = in_wait && found;
   // Misses include timeouts; a simultaneous found wins as a hit.
   assign miss_inc  = in_wait && !found && (not_found || (tcnt_reg == TMO_LAST));
   assign stat_inc  = {miss_inc, hit_inc};

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg    <= ST_IDLE;
         tcnt_reg     <= '0;
         request      <= '0;
         find         <= 1'b0;
         resp_valid   <= 1'b0;
         resp_hit     <= 1'b0;
         resp_timeout <= 1'b0;
         resp_data    <= '0;
         resp_id      <= '0;
         proto_err    <= 1'b0;
      end else begin
         find <= 1'b0;
         if ((found || not_found) && (!in_wait || (found && not_found))) begin
            proto_err <= 1'b1;
         end
         case (state_reg)
            ST_IDLE: begin
               if (req_valid) begin
                  request   <= pack_addr(32'(req_rank), 32'(req_tag), TAG_BIT) & ADDR_MASK;
                  resp_id   <= req_id;
                  find      <= 1'b1;
                  state_reg <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               tcnt_reg  <= '0;
               state_reg <= ST_WAIT_RES;
            end
            ST_WAIT_RES: begin
               if (found) begin
                  resp_hit     <= 1'b1;
                  resp_timeout <= 1'b0;
                  resp_data    <= unexpected_message;
                  resp_valid   <= 1'b1;
                  state_reg    <= ST_RESP;
               end else if (not_found || (tcnt_reg == TMO_LAST)) begin
                  resp_hit     <= 1'b0;
                  resp_timeout <= !not_found;
                  resp_data    <= '0;
                  resp_valid   <= 1'b1;
                  state_reg    <= ST_RESP;
               end else begin
                  tcnt_reg <= tcnt_reg + TW'(1);
               end
            end
            ST_RESP: begin
               if (resp_ready) begin
                  resp_valid <= 1'b0;
                  state_reg  <= ST_GAP;
               end
            end
            ST_GAP: begin
               // Lets the CAM retire the matched entry before the next find.
               state_reg <= ST_IDLE;
            end
            default: state_reg <= ST_IDLE;
         endcase
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_stat
         sat_counter #(.WIDTH(STAT_WIDTH)) u_cnt (
            .clk   (clk),
            .rst   (rst),
            .clr   (1'b0),
            .inc   (stat_inc[gi]),
            .count (stat_count[gi])
         );
      end
   endgenerate

   assign hit_count  = stat_count[0];
   assign miss_count = stat_count[1];

endmodule

// File: tb/tb_umq_find_ctrl.sv
// Directed bench for umq_find_ctrl with a small behavioural CAM responder.
module tb_umq_find_ctrl;

   localparam int SW = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic [7:0]  req_rank;
   logic [7:0]  req_tag;
   logic [7:0]  req_id;
   logic [31:0] request;
   logic        find;
   logic        found;
   logic        not_found;
   logic [31:0] unexpected_message;
   logic        resp_valid;
   logic        resp_ready;
   logic        resp_hit;
   logic        resp_timeout;
   logic [31:0] resp_data;
   logic [7:0]  resp_id;
   logic [SW-1:0] hit_count;
   logic [SW-1:0] miss_count;
   logic        proto_err;

   umq_find_ctrl #(.STAT_WIDTH(SW)) dut (
      .clk                (clk),
      .rst                (rst),
      .req_valid          (req_valid),
      .req_ready          (req_ready),
      .req_rank           (req_rank),
      .req_tag            (req_tag),
      .req_id             (req_id),
      .request            (request),
      .find               (find),
      .found              (found),
      .not_found          (not_found),
      .unexpected_message (unexpected_message),
      .resp_valid         (resp_valid),
      .resp_ready         (resp_ready),
      .resp_hit           (resp_hit),
      .resp_timeout       (resp_timeout),
      .resp_data          (resp_data),
      .resp_id            (resp_id),
      .hit_count          (hit_count),
      .miss_count         (miss_count),
      .proto_err          (proto_err)
   );

   always #5 clk = ~clk;

   int pass_cnt = 0;
   int chk_cnt  = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      chk_cnt++;
      if (obs === exp) begin
         pass_cnt++;
         $display("ok   %-16s got 0x%08h", tag, obs);
      end else begin
         $display("FAIL %-16s got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // CAM model: 0 = normal, 1 = silent, 2 = found+not_found together
   int          cam_mode = 0;
   logic [31:0] mem [int];
   int          find_cnt = 0;
   logic [31:0] last_req = '0;
   int          stray_req_n = 0;
   int          stray_ack_n = 0;

   initial begin
      int delay;
      int addr;
      found = 1'b0;
      not_found = 1'b0;
      unexpected_message = '0;
      forever begin
         @(negedge clk);
         if (stray_req_n != stray_ack_n) begin
            stray_ack_n++;
            not_found = 1'b1;
            @(posedge clk); #1;
            not_found = 1'b0;
         end else if (find) begin
            find_cnt++;
            last_req = request;
            addr = int'(request[15:0]);
            if (cam_mode != 1) begin
               delay = (mem.num() == 0) ? 1 : 2;
               repeat (delay) @(posedge clk);
               #1;
               if (cam_mode == 2) begin
                  found = 1'b1;
                  not_found = 1'b1;
                  unexpected_message = 32'h1234_5678;
               end else if (mem.exists(addr)) begin
                  found = 1'b1;
                  unexpected_message = mem[addr];
                  mem.delete(addr);
               end else begin
                  not_found = 1'b1;
               end
               @(posedge clk); #1;
               found = 1'b0;
               not_found = 1'b0;
               unexpected_message = '0;
            end
         end
      end
   end

   // Issue one lookup; called at #1 after a rising edge.
   task automatic lookup(input logic [7:0] rank, input logic [7:0] tag, input logic [7:0] id,
                         input int hold, output int lat, output logic hit, output logic tmo,
                         output logic [31:0] data, output logic [7:0] rid,
                         output logic stable, output logic gap_ok);
      logic [41:0] cap;
      int w = 0;
      while (!req_ready && w < 50) begin
         @(posedge clk); #1;
         w++;
      end
      req_rank = rank; req_tag = tag; req_id = id; req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      lat = 0;
      while (!resp_valid && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      hit = resp_hit; tmo = resp_timeout; data = resp_data; rid = resp_id;
      cap = {resp_hit, resp_timeout, resp_data, resp_id};
      stable = 1'b1;
      repeat (hold) begin
         @(posedge clk); #1;
         if ({resp_hit, resp_timeout, resp_data, resp_id} != cap || !resp_valid || req_ready)
            stable = 1'b0;
      end
      resp_ready = 1'b1;
      @(posedge clk); #1;
      resp_ready = 1'b0;
      gap_ok = !resp_valid && !req_ready;
      @(posedge clk); #1;
      gap_ok = gap_ok && req_ready;
   endtask

   initial begin
      int lat;
      logic hit, tmo, stable, gap_ok;
      logic [31:0] data;
      logic [7:0] rid;
      int f0;

      rst = 1'b1; req_valid = 1'b0; req_rank = '0; req_tag = '0; req_id = '0;
      resp_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      check("rst_req_ready", req_ready, 1);
      check("rst_resp_valid", resp_valid, 0);
      check("rst_find", find, 0);
      check("rst_counts", {hit_count, miss_count}, 0);

      // Empty CAM miss
      lookup(8'd3, 8'd5, 8'd7, 0, lat, hit, tmo, data, rid, stable, gap_ok);
      check("empty_req_addr", last_req, 32'h0000_0305);
      check("empty_latency", lat, 2);
      check("empty_hit", hit, 0);
      check("empty_data", data, 0);
      check("empty_id", rid, 7);
      check("empty_miss_cnt", miss_count, 1);
      check("empty_finds", find_cnt, 1);

      // Preloaded hit, then repeat misses because the entry is consumed
      mem[16'h0305] = 32'hDEAD_BEEF;
      lookup(8'd3, 8'd5, 8'd9, 0, lat, hit, tmo, data, rid, stable, gap_ok);
      check("hit_latency", lat, 3);
      check("hit_flag", hit, 1);
      check("hit_data", data, 32'hDEAD_BEEF);
      check("hit_cnt", hit_count, 1);
      lookup(8'd3, 8'd5, 8'd10, 0, lat, hit, tmo, data, rid, stable, gap_ok);
      check("rep_hit", hit, 0);
      check("rep_miss_cnt", miss_count, 2);

      // Back-to-back with stalled consumer
      mem[16'h0102] = 32'hCAFE_F00D;
      f0 = find_cnt;
      lookup(8'd1, 8'd2, 8'h21, 10, lat, hit, tmo, data, rid, stable, gap_ok);
      check("b2b1_stable", stable, 1);
      check("b2b1_gap", gap_ok, 1);
      check("b2b1_data", data, 32'hCAFE_F00D);
      lookup(8'd1, 8'd2, 8'h22, 10, lat, hit, tmo, data, rid, stable, gap_ok);
      check("b2b2_stable", stable, 1);
      check("b2b2_id", rid, 8'h22);
      check("b2b_finds", find_cnt - f0, 2);
      check("b2b_counts", {hit_count, miss_count}, {4'd2, 4'd3});

      // Silent CAM -> timeout
      cam_mode = 1;
      lookup(8'd4, 8'd4, 8'h33, 0, lat, hit, tmo, data, rid, stable, gap_ok);
      check("tmo_latency", lat, 16);
      check("tmo_flag", tmo, 1);
      check("tmo_hit", hit, 0);
      check("tmo_miss_cnt", miss_count, 4);
      check("tmo_proto", proto_err, 0);

      // found and not_found together
      cam_mode = 2;
      lookup(8'd5, 8'd6, 8'h44, 0, lat, hit, tmo, data, rid, stable, gap_ok);
      check("both_hit", hit, 1);
      check("both_data", data, 32'h1234_5678);
      check("both_proto", proto_err, 1);
      cam_mode = 0;
      lookup(8'd5, 8'd7, 8'h45, 0, lat, hit, tmo, data, rid, stable, gap_ok);
      check("proto_sticky", proto_err, 1);
      check("pre_sat_counts", {hit_count, miss_count}, {4'd3, 4'd5});

      // Hit counter saturation
      for (int i = 0; i < 13; i++) begin
         mem[16'h0A00 + i] = 32'h100 + i;
         lookup(8'h0A, 8'(i), 8'(i), 0, lat, hit, tmo, data, rid, stable, gap_ok);
         if (i == 11) check("sat_reach", hit_count, 15);
         if (i == 12) check("sat_hold", hit_count, 15);
      end
      check("sat_last_data", data, 32'h10C);

      // Reset while waiting for a CAM result
      cam_mode = 1;
      req_rank = 8'h77; req_tag = 8'h88; req_id = 8'h99; req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("wrst_request", request, 0);
      check("wrst_outs", {find, resp_valid, resp_hit, resp_timeout, proto_err}, 0);
      check("wrst_data_id", {resp_data, resp_id} == 0, 1);
      check("wrst_counts", {hit_count, miss_count}, 0);
      check("wrst_ready", req_ready, 1);
      repeat (20) @(posedge clk);
      #1;
      check("wrst_no_resp", resp_valid, 0);

      // Stray not_found in IDLE flags a protocol error
      cam_mode = 0;
      stray_req_n++;
      repeat (3) @(posedge clk);
      #1;
      check("stray_proto", proto_err, 1);

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
